fir_mac_sequencer: RTL and testbench
====================================

FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 SHALL have parameter NTAPS, default 8: number of filter taps, a power of two, at least 2.
REQ-002 SHALL have parameter DW, default 4: sample width in bits, signed two's complement.
REQ-003 SHALL have parameter CW, default 4: coefficient width in bits, signed two's complement.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, DW): sample input handshake.
REQ-007 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, ACCW): filtered result handshake.
REQ-008 SHALL have ports coef_we (input, 1), coef_addr (input, log2(NTAPS)) and coef_data (input, CW): coefficient write port.
REQ-009 SHALL have ports mul_tap (output, CW), mul_data (output, DW) and mul_prod (input, DW+CW): the external combinational multiplier operands and its signed product.
REQ-010 SHALL have port busy, output, 1 bit: high in states MAC and DONE.

Function
REQ-011 SHALL compute y[n] = sum over k = 0..NTAPS-1 of c[k]*x[n-k], using one mul_prod per cycle.
REQ-012 SHALL size ACCW = DW+CW+log2(NTAPS) (default 11).
REQ-013 SHALL sign-extend each product to ACCW bits before accumulating; no saturation is needed because overflow cannot occur.
REQ-014 SHALL implement the states IDLE, MAC and DONE.
REQ-015 SHALL assert in_ready only in IDLE; an accepted sample (in_valid && in_ready) is written at the ring write pointer, the accumulator clears, k is set to 0, and the state moves to MAC.
REQ-016 SHALL, in MAC, drive mul_tap=c[k] and mul_data=x[n-k] each cycle and add mul_prod into the accumulator.
REQ-017 SHALL increment k each MAC cycle and, after k=NTAPS-1, move to DONE, register out_data, and advance the write pointer.
REQ-018 SHALL keep out_valid high in DONE only; out_data SHALL hold stable until out_ready is high, then the state returns to IDLE.
REQ-019 SHALL meet this latency: for an acceptance in cycle 0 (out_ready held high), out_valid rises in cycle NTAPS+1, and in_ready is high again in cycle NTAPS+2.
REQ-020 SHALL wrap the write pointer from NTAPS-1 to 0, and SHALL compute read index = (wptr - k) mod NTAPS.
REQ-021 SHALL treat samples older than those received since reset as zero.
REQ-022 SHALL ignore coef_we outside IDLE; in IDLE the write takes effect the next cycle.
REQ-023 SHALL give the sample when in_valid and coef_we are both high in IDLE the coefficients as they were before that write.
REQ-024 SHALL drive mul_tap and mul_data to 0 outside MAC.

Reset
REQ-025 SHALL, on reset low at a clock edge, go to IDLE and clear the accumulator, k, wptr, all ring entries and all coefficients to 0.
REQ-026 SHALL hold these values after reset: in_ready=1, out_valid=0, out_data=0, busy=0, mul_tap=0, mul_data=0.
REQ-027 SHALL, on reset during MAC or DONE, abort the computation and not present its result.

Structure
REQ-028 SHALL keep NTAPS/DW/CW defaults, derived ACCW and the state enum (IDLE, MAC, DONE) in shared package fir_pkg.
REQ-029 SHALL contain one sub-module, fir_sample_ring: an NTAPS x DW circular buffer with write port, wptr and indexed read port.
REQ-030 SHALL stay outside the block for the multiplier, so the existing math unit can be shared.

Verification
REQ-031 Single-tap check: c[0]=1, others 0; feed sample 5 -> out_data=5, with out_valid rising NTAPS+1 cycles after acceptance.
REQ-032 Impulse response: c={1,2,3,-1,0,0,0,0}; feed 1 then seven 0 samples -> outputs 1,2,3,-1,0,0,0,0.
REQ-033 Worst-case range: all c=-8, feed eight samples of -8 -> eighth out_data=+512, with no wrap in ACCW=11.
REQ-034 Backpressure: hold out_ready low 3 cycles in DONE -> out_data stable, in_ready=0, in_valid ignored; the result is consumed on the first out_ready=1 edge.
REQ-035 Coefficient gating: write c[0]=7 during MAC -> ignored, so the current and next results use the old c[0].
REQ-036 Reset mid-MAC: pull reset low at MAC cycle 3 -> no out_valid; afterwards a sample of 2 with c[0]=1 gives 2, with zero history.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared defaults, width helper and state encoding for the FIR MAC sequencer.
package fir_pkg;

    localparam int unsigned NTAPS_DEF = 8;
    localparam int unsigned DW_DEF    = 4;
    localparam int unsigned CW_DEF    = 4;

    // Accumulator wide enough that a full sum of NTAPS products cannot overflow.
    function automatic int unsigned acc_width(input int unsigned ntaps,
                                              input int unsigned dw,
                                              input int unsigned cw);
        return dw + cw + $clog2(ntaps);
    endfunction

    localparam int unsigned ACCW_DEF = acc_width(NTAPS_DEF, DW_DEF, CW_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Sample-in, result-out and coefficient-write signals of the FIR MAC sequencer.
interface fir_mac_sequencer_if
    import fir_pkg::*;
#(
    parameter int unsigned NTAPS = NTAPS_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned CW    = CW_DEF
);
    localparam int unsigned AW   = $clog2(NTAPS);
    localparam int unsigned ACCW = acc_width(NTAPS, DW, CW);

    logic                   in_valid;
    logic                   in_ready;
    logic signed [DW-1:0]   in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [ACCW-1:0] out_data;
    logic                   coef_we;
    logic [AW-1:0]          coef_addr;
    logic signed [CW-1:0]   coef_data;

    modport master (
        output in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/fir_sample_ring.sv
// NTAPS-deep circular sample history with a write pointer and a random read port.
module fir_sample_ring
    import fir_pkg::*;
#(
    parameter int unsigned NTAPS = NTAPS_DEF,
    parameter int unsigned DW    = DW_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we,
    input  logic signed [DW-1:0]       wdata,
    input  logic                       adv,
    output logic [$clog2(NTAPS)-1:0]   wptr,
    input  logic [$clog2(NTAPS)-1:0]   rd_idx,
    output logic signed [DW-1:0]       rd_data
);
    localparam int unsigned AW = $clog2(NTAPS);

    logic signed [DW-1:0] mem [NTAPS];

    // Clearing the entries on reset makes pre-reset history read as zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(NTAPS); i++) begin
                mem[i] <= '0;
            end
            wptr <= '0;
        end else begin
            if (we) begin
                mem[wptr] <= wdata;
            end
            if (adv) begin
                wptr <= wptr + AW'(1);
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one external multiply per cycle, NTAPS cycles per output sample.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int unsigned NTAPS = NTAPS_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned CW    = CW_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    fir_mac_sequencer_if.slave      bus,
    output logic signed [CW-1:0]    mul_tap,
    output logic signed [DW-1:0]    mul_data,
    input  logic signed [DW+CW-1:0] mul_prod,
    output logic                    busy
);
    localparam int unsigned AW   = $clog2(NTAPS);
    localparam int unsigned ACCW = acc_width(NTAPS, DW, CW);
    localparam logic [AW-1:0] KLAST = AW'(NTAPS - 1);

    state_t                 state, state_nxt;
    logic [AW-1:0]          k, k_nxt;
    logic signed [ACCW-1:0] acc, acc_nxt;
    logic signed [ACCW-1:0] out_data_q, out_data_nxt;
    logic signed [ACCW-1:0] prod_ext;
    logic                   in_ready_q, out_valid_q, busy_q;
    logic                   accept, ring_adv;
    logic [AW-1:0]          wptr, rd_idx;
    logic signed [DW-1:0]   rd_data;
    logic signed [CW-1:0]   coef [NTAPS];
    logic                   pend_we;
    logic [AW-1:0]          pend_addr;
    logic signed [CW-1:0]   pend_data;

    assign accept   = (state == IDLE) && bus.in_valid;
    assign rd_idx   = wptr - k;
    assign prod_ext = ACCW'(mul_prod);

    fir_sample_ring #(
        .NTAPS (NTAPS),
        .DW    (DW)
    ) u_ring (
        .clk     (clk),
        .reset   (reset),
        .we      (accept),
        .wdata   (bus.in_data),
        .adv     (ring_adv),
        .wptr    (wptr),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    // Next-state, datapath and multiplier operand decode.
    always_comb begin
        state_nxt    = state;
        k_nxt        = k;
        acc_nxt      = acc;
        out_data_nxt = out_data_q;
        ring_adv     = 1'b0;
        mul_tap      = '0;
        mul_data     = '0;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nxt = MAC;
                    k_nxt     = '0;
                    acc_nxt   = '0;
                end
            end
            MAC: begin
                mul_tap  = coef[k];
                mul_data = rd_data;
                acc_nxt  = acc + prod_ext;
                k_nxt    = k + AW'(1);
                if (k == KLAST) begin
                    state_nxt    = DONE;
                    out_data_nxt = acc + prod_ext;
                    ring_adv     = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            k           <= '0;
            acc         <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            k           <= k_nxt;
            acc         <= acc_nxt;
            out_data_q  <= out_data_nxt;
            in_ready_q  <= (state_nxt == IDLE);
            out_valid_q <= (state_nxt == DONE);
            busy_q      <= (state_nxt != IDLE);
        end
    end

    // A write that coincides with sample acceptance is parked until that result is consumed,
    // so the sample in flight still sees the old coefficient set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(NTAPS); i++) begin
                coef[i] <= '0;
            end
            pend_we   <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
        end else if ((state == IDLE) && bus.coef_we) begin
            if (bus.in_valid) begin
                pend_we   <= 1'b1;
                pend_addr <= bus.coef_addr;
                pend_data <= bus.coef_data;
            end else begin
                coef[bus.coef_addr] <= bus.coef_data;
            end
        end else if ((state == DONE) && bus.out_ready && pend_we) begin
            coef[pend_addr] <= pend_data;
            pend_we         <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with an ideal signed multiplier on the side.
module tb_fir_mac_sequencer;
    import fir_pkg::*;

    localparam int unsigned NTAPS = NTAPS_DEF;
    localparam int unsigned DW    = DW_DEF;
    localparam int unsigned CW    = CW_DEF;
    localparam int unsigned AW    = $clog2(NTAPS);
    localparam int unsigned ACCW  = ACCW_DEF;

    logic                    clk;
    logic                    reset;
    logic signed [CW-1:0]    mul_tap;
    logic signed [DW-1:0]    mul_data;
    logic signed [DW+CW-1:0] mul_prod;
    logic                    busy;

    int errors;
    int checks;

    fir_mac_sequencer_if #(.NTAPS(NTAPS), .DW(DW), .CW(CW)) bus ();

    fir_mac_sequencer #(
        .NTAPS (NTAPS),
        .DW    (DW),
        .CW    (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .mul_tap  (mul_tap),
        .mul_data (mul_data),
        .mul_prod (mul_prod),
        .busy     (busy)
    );

    assign mul_prod = mul_tap * mul_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic wcoef(input int a, input int d);
        bus.coef_we   = 1'b1;
        bus.coef_addr = AW'(a);
        bus.coef_data = CW'(d);
        step();
        bus.coef_we   = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, int'(bus.out_valid), 1);
    endtask

    // Push one sample, check the result, let it be consumed (out_ready held high).
    task automatic send(input int x, input int exp_y, input string tag);
        logic signed [ACCW-1:0] y;
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(x);
        step();
        bus.in_valid = 1'b0;
        wait_valid(tag);
        y = bus.out_data;
        chk(tag, int'(y), exp_y);
        step();
    endtask

    initial begin
        int lat;
        int seen;
        errors        = 0;
        checks        = 0;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        do_reset();

        // Reset values
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_mul_tap", int'(mul_tap), 0);
        chk("rst_mul_data", int'(mul_data), 0);

        // Single tap with latency
        wcoef(0, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(5);
        step();
        bus.in_valid = 1'b0;
        lat = 1;
        chk("mac0_mul_tap", int'(mul_tap), 1);
        chk("mac0_mul_data", int'(mul_data), 5);
        chk("mac0_busy", int'(busy), 1);
        chk("mac0_in_ready", int'(bus.in_ready), 0);
        while (!bus.out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk("single_latency", lat, int'(NTAPS) + 1);
        chk("single_out", int'(bus.out_data), 5);
        chk("done_busy", int'(busy), 1);
        chk("done_mul_tap", int'(mul_tap), 0);
        chk("done_in_ready", int'(bus.in_ready), 0);
        step();
        chk("ready_again", int'(bus.in_ready), 1);
        chk("valid_dropped", int'(bus.out_valid), 0);

        // Impulse response
        do_reset();
        wcoef(0, 1);
        wcoef(1, 2);
        wcoef(2, 3);
        wcoef(3, -1);
        send(1, 1, "imp0");
        send(0, 2, "imp1");
        send(0, 3, "imp2");
        send(0, -1, "imp3");
        send(0, 0, "imp4");
        send(0, 0, "imp5");
        send(0, 0, "imp6");
        send(0, 0, "imp7");

        // Worst-case range: y[n] = 64*(n+1)
        do_reset();
        for (int i = 0; i < 8; i++) wcoef(i, -8);
        send(-8, 64, "wc0");
        send(-8, 128, "wc1");
        send(-8, 192, "wc2");
        send(-8, 256, "wc3");
        send(-8, 320, "wc4");
        send(-8, 384, "wc5");
        send(-8, 448, "wc6");
        send(-8, 512, "wc7");

        // Backpressure
        do_reset();
        wcoef(0, 1);
        wcoef(1, 1);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = DW'(3);
        step();
        bus.in_valid  = 1'b0;
        wait_valid("bp");
        chk("bp_out", int'(bus.out_data), 3);
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(6);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_valid", int'(bus.out_valid), 1);
            chk("bp_hold_data", int'(bus.out_data), 3);
            chk("bp_hold_in_ready", int'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("bp_consumed", int'(bus.out_valid), 0);
        chk("bp_in_ready", int'(bus.in_ready), 1);
        send(4, 7, "bp_next");

        // Coefficient write during MAC is ignored
        do_reset();
        wcoef(0, 1);
        wcoef(1, 2);
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(3);
        step();
        bus.in_valid  = 1'b0;
        bus.coef_we   = 1'b1;
        bus.coef_addr = AW'(0);
        bus.coef_data = CW'(7);
        step();
        bus.coef_we = 1'b0;
        wait_valid("gate");
        chk("gate_cur", int'(bus.out_data), 3);
        step();
        send(1, 7, "gate_next");

        // Coefficient write coinciding with acceptance
        do_reset();
        wcoef(0, 1);
        bus.in_valid  = 1'b1;
        bus.in_data   = DW'(3);
        bus.coef_we   = 1'b1;
        bus.coef_addr = AW'(0);
        bus.coef_data = CW'(2);
        step();
        bus.in_valid = 1'b0;
        bus.coef_we  = 1'b0;
        wait_valid("simul");
        chk("simul_old_coef", int'(bus.out_data), 3);
        step();
        send(1, 2, "simul_new_coef");

        // Reset in the middle of MAC
        do_reset();
        wcoef(0, 1);
        wcoef(1, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(5);
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid) seen++;
            step();
        end
        chk("abort_no_valid", seen, 0);
        chk("abort_in_ready", int'(bus.in_ready), 1);
        wcoef(0, 1);
        wcoef(1, 1);
        send(2, 2, "abort_zero_hist");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
